// File: rtl/fix_to_fp_11_12.sv
// Three-stage valid/ready pipeline that converts signed fixed-point to the wE=11/wF=12 float
// format (exc, sign, exponent, fraction) with round-to-nearest-even.
module fix_to_fp_11_12 #(
    parameter int unsigned WIN     = 24,
    parameter int unsigned FRAC_IN = 0,
    parameter int unsigned BIAS    = 1023
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIN-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [25:0]    out_data
);

    localparam int unsigned LW   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int          EOFF = int'(BIAS) - int'(FRAC_IN);
    localparam int unsigned XW   = WIN + 14;

    logic w_adv;

    // Stage 1: sign / magnitude
    logic           r_s1_valid;
    logic           r_s1_sign;
    logic           r_s1_zero;
    logic [WIN-1:0] r_s1_mag;
    logic [WIN-1:0] w_s1_mag;

    // Stage 2: normalised fields
    logic           r_s2_valid;
    logic           r_s2_sign;
    logic           r_s2_zero;
    logic [11:0]    r_s2_frac;
    logic           r_s2_guard;
    logic           r_s2_sticky;
    logic [10:0]    r_s2_exp;

    logic [LW-1:0]  w_lead;
    logic [LW-1:0]  w_shamt;
    logic [WIN-1:0] w_norm;
    logic [XW-1:0]  w_ext;
    logic [11:0]    w_frac;
    logic           w_guard;
    logic           w_sticky;
    int             w_exp_full;
    logic [10:0]    w_exp;

    // Stage 3: rounded and packed result
    logic           r_out_valid;
    logic [25:0]    r_out_data;
    logic           w_round_up;
    logic [12:0]    w_frac_sum;
    logic [10:0]    w_exp_rnd;
    logic [25:0]    w_pack;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // Negating -2^(WIN-1) wraps back to 2^(WIN-1), which is the correct unsigned magnitude.
    assign w_s1_mag = in_data[WIN-1] ? (~in_data + WIN'(1)) : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
        end
        if (w_adv) begin
            r_s1_sign <= in_data[WIN-1];
            r_s1_zero <= (in_data == '0);
            r_s1_mag  <= w_s1_mag;
        end
    end

    always_comb begin
        w_lead = '0;
        for (int i = 0; i < int'(WIN); i++) begin
            if (r_s1_mag[i]) begin
                w_lead = LW'(i);
            end
        end
    end

    // Bits below the shifted magnitude are zero-filled so narrow inputs still yield 12+G bits.
    assign w_shamt    = LW'(WIN - 1) - w_lead;
    assign w_norm     = r_s1_mag << w_shamt;
    assign w_ext      = {w_norm, 14'd0};
    assign w_frac     = w_ext[XW-2 -: 12];
    assign w_guard    = w_ext[WIN];
    assign w_sticky   = |w_ext[WIN-1:0];
    assign w_exp_full = int'(w_lead) + EOFF;
    assign w_exp      = w_exp_full[10:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
        end
        if (w_adv) begin
            r_s2_sign   <= r_s1_sign;
            r_s2_zero   <= r_s1_zero;
            r_s2_frac   <= w_frac;
            r_s2_guard  <= w_guard;
            r_s2_sticky <= w_sticky;
            r_s2_exp    <= w_exp;
        end
    end

    assign w_round_up = r_s2_guard & (r_s2_sticky | r_s2_frac[0]);
    assign w_frac_sum = {1'b0, r_s2_frac} + {12'd0, w_round_up};
    assign w_exp_rnd  = r_s2_exp + {10'd0, w_frac_sum[12]};
    assign w_pack     = r_s2_zero ? 26'd0 : {2'b01, r_s2_sign, w_exp_rnd, w_frac_sum[11:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 26'd0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            r_out_data  <= r_s2_valid ? w_pack : 26'd0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_fix_to_fp_11_12.sv
// Scoreboard bench for fix_to_fp_11_12: random stimulus checked against an arithmetic RNE model,
// plus directed latency, rounding, backpressure, reset-flush and FRAC_IN=8 cases.
module tb_fix_to_fp_11_12;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_data;

    logic        in_valid8;
    logic        in_ready8;
    logic [23:0] in_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [25:0] out_data8;

    int checks   = 0;
    int failures = 0;

    logic [25:0] exp_q[$];
    int          n_pushed   = 0;
    int          n_popped   = 0;
    int          ready_mode = 0;
    int          low_burst  = 0;
    bit          saw_bp     = 1'b0;
    bit          prev_stall = 1'b0;
    logic [25:0] prev_data  = '0;

    always #5 clk = ~clk;

    fix_to_fp_11_12 #(.WIN(24), .FRAC_IN(0), .BIAS(1023)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    fix_to_fp_11_12 #(.WIN(24), .FRAC_IN(8), .BIAS(1023)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .in_data  (in_data8),
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .out_data (out_data8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Exact integer magnitude rounded to a 13-bit significand, ties to even.
    function automatic logic [25:0] ref_fp(input logic [23:0] d, input int frac_in);
        longint v, mag, keep, rem, half;
        int     p, sh;
        logic   s;
        logic [10:0] e;
        v = longint'($signed(d));
        if (v == 0) return 26'd0;
        s   = (v < 0);
        mag = s ? -v : v;
        p   = 0;
        for (int i = 0; i < 24; i++) if (mag >= (longint'(1) << i)) p = i;
        if (p > 12) begin
            sh   = p - 12;
            keep = mag >> sh;
            rem  = mag - (keep << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (keep % 2) == 1)) keep++;
            if (keep == 8192) begin
                keep = 4096;
                p++;
            end
        end else begin
            keep = mag << (12 - p);
        end
        e = 11'(p - frac_in + 1023);
        return {2'b01, s, e, 12'(keep)};
    endfunction

    always @(posedge clk) begin
        #1;
        if (low_burst > 0) begin
            out_ready = 1'b0;
            low_burst = low_burst - 1;
        end else if (ready_mode == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Input side: the expected result is queued at the moment of transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(ref_fp(in_data, 0));
            n_pushed++;
            if (in_valid && !in_ready) saw_bp = 1'b1;
        end else if (in_valid && !in_ready) begin
            saw_bp = 1'b1;
        end
    end

    // Output side: compare on every output transfer, and hold-stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {6'd0, out_data}, {6'd0, prev_data});
            end
            if (out_valid) check("exc_not_special", {31'd0, out_data[25]}, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stale_output: got 0x%0h required no output", out_data);
                end else begin
                    check("scoreboard", {6'd0, out_data}, {6'd0, exp_q.pop_front()});
                end
                n_popped++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send(input logic [23:0] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts rising edges from the accepting edge (inclusive) to out_valid.
    task automatic directed(input string name, input logic [23:0] d, input logic [25:0] expv);
        int cnt;
        send(d);
        cnt = 1;
        @(negedge clk);
        while (!out_valid && cnt < 10) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check({name, "_latency"}, cnt, 32'd3);
        check(name, {6'd0, out_data}, {6'd0, expv});
        @(posedge clk);
        #1;
    endtask

    task automatic directed8(input string name, input logic [23:0] d, input logic [25:0] expv);
        int cnt;
        in_valid8 = 1'b1;
        in_data8  = d;
        @(negedge clk);
        check({name, "_ready"}, {31'd0, in_ready8}, 32'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        cnt = 1;
        @(negedge clk);
        while (!out_valid8 && cnt < 10) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check({name, "_latency"}, cnt, 32'd3);
        check(name, {6'd0, out_data8}, {6'd0, expv});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d entries pending required 0", exp_q.size());
        end
        #1;
    endtask

    function automatic logic [23:0] rand_value();
        logic [23:0] v;
        int          sh;
        case ($urandom_range(0, 4))
            0: v = 24'($urandom);
            1: v = 24'($urandom_range(0, 64)) - 24'd32;
            2: begin
                sh = $urandom_range(0, 22);
                v  = (24'd1 << sh) + 24'($urandom_range(0, 2)) - 24'd1;
            end
            3: v = 24'h800000;
            default: begin
                sh = $urandom_range(0, 11);
                v  = 24'($urandom) >> sh;
            end
        endcase
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed0, popped0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_valid8  = 1'b0;
        in_data8   = '0;
        out_ready  = 1'b1;
        out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", {6'd0, out_data}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        directed("one", 24'd1, 26'h13FF000);
        directed("minus_one", 24'hFFFFFF, 26'h1BFF000);
        directed("three", 24'd3, 26'h1400800);
        directed("zero", 24'd0, 26'h0000000);
        directed("tie_even_down", 24'd8193, 26'h140C000);
        directed("tie_round_up", 24'd8195, 26'h140C002);
        directed("mant_carry", 24'd16383, 26'h140D000);
        directed("most_negative", 24'h800000, 26'h1C16000);

        directed8("frac8_one", 24'h000100, 26'h13FF000);
        directed8("frac8_half", 24'h000080, 26'h13FE000);

        // Reset with two values in flight.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 24'd5;
        @(posedge clk);
        #1;
        in_data = 24'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_out_data", {6'd0, out_data}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("flush_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        directed("after_flush", 24'd3, 26'h1400800);

        // Backpressure burst of 10.
        pushed0    = n_pushed;
        popped0    = n_popped;
        saw_bp     = 1'b0;
        ready_mode = 1;
        low_burst  = 5;
        for (int i = 0; i < 10; i++) send(rand_value());
        drain();
        check("bp_in_ready_dropped", {31'd0, saw_bp}, 32'd1);
        check("bp_pushed", n_pushed - pushed0, 32'd10);
        check("bp_popped", n_popped - popped0, 32'd10);

        // Random sweep.
        pushed0 = n_pushed;
        popped0 = n_popped;
        for (int i = 0; i < 20000; i++) begin
            send(rand_value());
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        check("sweep_pushed", n_pushed - pushed0, 32'd20000);
        check("sweep_popped", n_popped - popped0, 32'd20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
